alu_seq_param: RTL and testbench

Parametrised, handshaked successor to the 8-bit combinational generated ALU. It implements all twelve opcodes, including the compare group (SEQ, SGT, SLTU, SGE) with defined results. MUL is a multi-cycle shift-add operation; every other opcode completes in a single registered cycle. The block sits between an operand-issue stage and a writeback stage, using valid/ready on both sides.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_seq_param_if.sv | 31 +++
 rtl/alu_mul_iter.sv | 57 +++++
 rtl/alu_seq_param.sv | 153 +++++++++++++++
 tb/tb_alu_seq_param.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcode map and FSM encoding for the sequential ALU.
package alu_pkg;

  localparam int unsigned OPW = 4;

  localparam logic [OPW-1:0] OP_ADD  = 4'd0;
  localparam logic [OPW-1:0] OP_SUB  = 4'd1;
  localparam logic [OPW-1:0] OP_AND  = 4'd2;
  localparam logic [OPW-1:0] OP_OR   = 4'd3;
  localparam logic [OPW-1:0] OP_SLL  = 4'd4;
  localparam logic [OPW-1:0] OP_SEQ  = 4'd5;
  localparam logic [OPW-1:0] OP_NOR  = 4'd6;
  localparam logic [OPW-1:0] OP_SGT  = 4'd7;
  localparam logic [OPW-1:0] OP_SLTU = 4'd8;
  localparam logic [OPW-1:0] OP_SRA  = 4'd9;
  localparam logic [OPW-1:0] OP_MUL  = 4'd10;
  localparam logic [OPW-1:0] OP_SGE  = 4'd11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    DONE     = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_param_if.sv
// Issue-side and writeback-side handshake bundle of the sequential ALU.
interface alu_seq_param_if
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = 5
);

  logic             in_valid;
  logic             in_ready;
  logic [OPW-1:0]   opcode;
  logic [WIDTH-1:0] input1;
  logic [WIDTH-1:0] input2;
  logic [SHW-1:0]   shiftValue;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carryFlag;
  logic             err_illegal;

  modport master (
    output in_valid, opcode, input1, input2, shiftValue, out_ready,
    input  in_ready, out_valid, result, carryFlag, err_illegal
  );

  modport slave (
    input  in_valid, opcode, input1, input2, shiftValue, out_ready,
    output in_ready, out_valid, result, carryFlag, err_illegal
  );

endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH steps.
module alu_mul_iter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic          busy;
  logic [CW-1:0] cnt;
  logic [PW-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0] acc;

  // Load operands on start, then add the shifted multiplicand for each set multiplier bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy   <= 1'b1;
        cnt    <= '0;
        mcand  <= PW'(a);
        mplier <= b;
        acc    <= '0;
      end else if (busy) begin
        if (mplier[0]) begin
          acc <= acc + mcand;
        end
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign product = acc;

endmodule

// File: rtl/alu_seq_param.sv
// Handshaked parametrised ALU: single-cycle ops plus an iterative MUL.
module alu_seq_param
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_seq_param_if.slave bus
);

  localparam int unsigned PW = 2 * WIDTH;

  state_t state_q, state_d;

  logic             accept;
  logic             is_mul;
  logic             mul_start;
  logic             mul_done;
  logic             load_alu;
  logic             load_mul;
  logic [PW-1:0]    product;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SHW-1:0]   sh;
  logic             sh_big;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] res_c;
  logic             cy_c;
  logic             ill_c;

  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             err_q;
  logic             out_valid_q;
  logic             in_ready_q;

  assign a      = bus.input1;
  assign b      = bus.input2;
  assign sh     = bus.shiftValue;
  assign accept = bus.in_valid & in_ready_q;
  assign is_mul = (bus.opcode == OP_MUL);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (product)
  );

  // Single-cycle result for every non-MUL opcode; shifts saturate at WIDTH.
  always_comb begin
    res_c  = '0;
    cy_c   = 1'b0;
    ill_c  = 1'b0;
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} - {1'b0, b};
    sh_big = (32'(sh) >= 32'(WIDTH));
    case (bus.opcode)
      OP_ADD:  begin res_c = sum[WIDTH-1:0];  cy_c = sum[WIDTH];  end
      OP_SUB:  begin res_c = diff[WIDTH-1:0]; cy_c = diff[WIDTH]; end
      OP_AND:  res_c = a & b;
      OP_OR:   res_c = a | b;
      OP_NOR:  res_c = ~(a | b);
      OP_SLL:  res_c = sh_big ? '0 : (a << sh);
      OP_SRA:  res_c = sh_big ? {WIDTH{a[WIDTH-1]}} : WIDTH'($signed(a) >>> sh);
      OP_SEQ:  res_c = {{(WIDTH-1){1'b0}}, (a == b)};
      OP_SGT:  res_c = {{(WIDTH-1){1'b0}}, ($signed(a) > $signed(b))};
      OP_SLTU: res_c = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SGE:  res_c = {{(WIDTH-1){1'b0}}, ($signed(a) >= $signed(b))};
      OP_MUL:  res_c = '0;
      default: ill_c = 1'b1;
    endcase
  end

  // Next-state and load strobes.
  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    load_alu  = 1'b0;
    load_mul  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_mul) begin
            mul_start = 1'b1;
            state_d   = MUL_BUSY;
          end else begin
            load_alu  = 1'b1;
            state_d   = DONE;
          end
        end
      end
      MUL_BUSY: begin
        if (mul_done) begin
          load_mul = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered handshake flags and result payload; payload holds while in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      carry_q     <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      out_valid_q <= (state_d == DONE);
      in_ready_q  <= (state_d == IDLE);
      if (load_alu) begin
        result_q <= res_c;
        carry_q  <= cy_c;
        err_q    <= ill_c;
      end else if (load_mul) begin
        result_q <= product[WIDTH-1:0];
        carry_q  <= |product[PW-1:WIDTH];
        err_q    <= 1'b0;
      end
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.result      = result_q;
  assign bus.carryFlag   = carry_q;
  assign bus.err_illegal = err_q;

endmodule

// File: tb/tb_alu_seq_param.sv
// Directed plus randomized bench for alu_seq_param against an arithmetic reference model.
module tb_alu_seq_param;
  import alu_pkg::*;

  localparam int unsigned W = 8;
  localparam int unsigned S = 5;
  localparam int MASK = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  int   ncmp  = 0;
  int   nfail = 0;

  always #5 clk = ~clk;

  alu_seq_param_if #(.WIDTH(W), .SHW(S)) bus ();

  alu_seq_param #(.WIDTH(W), .SHW(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: operands as plain integers, results masked to W bits.
  function automatic void model(input int op, input int a, input int b, input int sh,
                                output int res, output int cy, output int il);
    int sa, sb, p;
    sa  = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
    sb  = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
    res = 0;
    cy  = 0;
    il  = 0;
    case (op)
      0:  begin res = (a + b) & MASK; cy = (a + b > MASK) ? 1 : 0; end
      1:  begin res = (a - b) & MASK; cy = (a < b) ? 1 : 0; end
      2:  res = a & b;
      3:  res = a | b;
      4:  res = (sh >= W) ? 0 : ((a << sh) & MASK);
      5:  res = (a == b) ? 1 : 0;
      6:  res = (~(a | b)) & MASK;
      7:  res = (sa > sb) ? 1 : 0;
      8:  res = (a < b) ? 1 : 0;
      9:  res = (sh >= W) ? ((sa < 0) ? MASK : 0) : ((sa >>> sh) & MASK);
      10: begin p = a * b; res = p & MASK; cy = (p > MASK) ? 1 : 0; end
      11: res = (sa >= sb) ? 1 : 0;
      default: il = 1;
    endcase
  endfunction

  // Issue one op, check latency and payload, optionally stall the consumer for 'hold' cycles.
  task automatic run_op(input int op, input int a, input int b, input int sh, input int hold);
    int er, ec, ei, n, lat_exp;
    model(op, a, b, sh, er, ec, ei);
    lat_exp = (op == 10) ? W + 1 : 0;
    @(negedge clk);
    bus.opcode     = 4'(op);
    bus.input1     = W'(a);
    bus.input2     = W'(b);
    bus.shiftValue = S'(sh);
    bus.in_valid   = 1'b1;
    bus.out_ready  = 1'b0;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = (hold == 0);
    @(negedge clk);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      check("busy_in_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      n++;
    end
    check("out_valid", 32'(bus.out_valid), 32'd1);
    check("latency", 32'(n), 32'(lat_exp));
    check("result", 32'(bus.result), 32'(er));
    check("carry", 32'(bus.carryFlag), 32'(ec));
    check("err_illegal", 32'(bus.err_illegal), 32'(ei));
    check("done_in_ready", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid   = 1'b1;
      bus.opcode     = 4'($urandom_range(0, 15));
      bus.input1     = W'($urandom_range(0, MASK));
      bus.input2     = W'($urandom_range(0, MASK));
      bus.shiftValue = S'($urandom_range(0, 31));
      @(negedge clk);
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_result", 32'(bus.result), 32'(er));
      check("hold_carry", 32'(bus.carryFlag), 32'(ec));
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("handoff_valid", 32'(bus.out_valid), 32'd0);
    check("handoff_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n          = 1'b1;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    bus.opcode     = '0;
    bus.input1     = '0;
    bus.input2     = '0;
    bus.shiftValue = '0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_carry", 32'(bus.carryFlag), 32'd0);
    check("rst_err", 32'(bus.err_illegal), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_edge_ready", 32'(bus.in_ready), 32'd1);

    // Directed cases.
    run_op(0,  'hFF, 'h01, 0, 0);
    run_op(1,  'h01, 'h02, 0, 0);
    run_op(10, 'h0F, 'h0F, 0, 0);
    run_op(10, 'h10, 'h10, 0, 1);
    run_op(9,  'h80, 0, 3, 0);
    run_op(9,  'h80, 0, 9, 0);
    run_op(4,  'h81, 0, 1, 0);
    run_op(4,  'h81, 0, 8, 0);
    run_op(7,  'h80, 'h01, 0, 0);
    run_op(8,  'h01, 'h80, 0, 0);
    run_op(11, 'h05, 'h05, 0, 0);
    run_op(5,  'h05, 'h06, 0, 0);
    run_op(2,  'hF0, 'h3C, 0, 5);
    run_op(13, 'h12, 'h34, 0, 0);
    run_op(6,  'h0F, 'h30, 0, 0);
    run_op(3,  'h0F, 'h30, 0, 0);

    // Randomized cases.
    for (int i = 0; i < 40; i++) begin
      run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, MASK)),
             int'($urandom_range(0, MASK)), int'($urandom_range(0, 31)),
             int'($urandom_range(0, 2)));
    end

    // Asynchronous reset in the middle of a MUL.
    run_op(0, 'h12, 'h34, 0, 0);
    @(negedge clk);
    bus.opcode   = OP_MUL;
    bus.input1   = 8'h0F;
    bus.input2   = 8'h0F;
    bus.in_valid = 1'b1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midmul_rst_valid", 32'(bus.out_valid), 32'd0);
    check("midmul_rst_result", 32'(bus.result), 32'd0);
    check("midmul_rst_carry", 32'(bus.carryFlag), 32'd0);
    check("midmul_rst_err", 32'(bus.err_illegal), 32'd0);
    check("midmul_rst_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("no_stale_valid", 32'(bus.out_valid), 32'd0);
    end
    run_op(0, 'h3C, 'h0A, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
